// File: rtl/tb_arb_pkg.sv
// Shared types for the core/SBA data-port arbiter: response route IDs and
// the request payload carried on each master port.
package tb_arb_pkg;

  localparam int ArbAddrWidth = 32;
  localparam int ArbDataWidth = 32;

  typedef enum logic {
    ROUTE_CORE = 1'b0,
    ROUTE_SB   = 1'b1
  } route_e;

  typedef struct packed {
    logic [ArbAddrWidth-1:0]   addr;
    logic                      we;
    logic [ArbDataWidth/8-1:0] be;
    logic [ArbDataWidth-1:0]   wdata;
  } arb_req_t;

endpackage

// File: rtl/tb_route_fifo.sv
// Small in-order FIFO that remembers which master owns each outstanding
// RAM transaction. Push is refused when full, even alongside a pop.
module tb_route_fifo
  import tb_arb_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter int  WIDTH = 1,
  localparam int CntW  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CntW-1:0]  o_usage
);

  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Explicit wrap so non-power-of-two depths still cycle correctly.
  function automatic logic [PtrW-1:0] f_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign o_full    = (r_count == CntW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_usage   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= f_inc(r_wptr);
      if (w_pop_ok)  r_rptr <= f_inc(r_rptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tb_sba_data_arbiter.sv
// Shares the simulation RAM data port between the core and the debug SBA
// master; responses are steered back in issue order via the route FIFO.
module tb_sba_data_arbiter
  import tb_arb_pkg::*;
#(
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2,
  parameter int SbaPriority    = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic                   core_req_i,
  output logic                   core_gnt_o,
  input  logic [AddrWidth-1:0]   core_addr_i,
  input  logic                   core_we_i,
  input  logic [DataWidth/8-1:0] core_be_i,
  input  logic [DataWidth-1:0]   core_wdata_i,
  output logic                   core_rvalid_o,
  output logic [DataWidth-1:0]   core_rdata_o,

  input  logic                   sb_req_i,
  output logic                   sb_gnt_o,
  input  logic [AddrWidth-1:0]   sb_addr_i,
  input  logic                   sb_we_i,
  input  logic [DataWidth/8-1:0] sb_be_i,
  input  logic [DataWidth-1:0]   sb_wdata_i,
  output logic                   sb_rvalid_o,
  output logic [DataWidth-1:0]   sb_rdata_o,

  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i,

  output logic                   err_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic            r_last_sb;
  logic            r_lock;
  logic            r_lock_sb;
  logic            r_err;
  logic            w_sel_sb;
  logic            w_sel_req;
  logic            w_hs;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [0:0]      w_head;
  logic [CntW-1:0] w_usage;
  route_e          w_push_route;
  route_e          w_head_route;

  // A locked selection holds until its grant so the pending request cannot be preempted.
  always_comb begin
    w_sel_sb = sb_req_i;
    if (r_lock) begin
      w_sel_sb = r_lock_sb;
    end else if (core_req_i && sb_req_i) begin
      w_sel_sb = (SbaPriority != 0) ? 1'b1 : ~r_last_sb;
    end
  end

  assign w_sel_req   = w_sel_sb ? sb_req_i : core_req_i;
  assign mem_req_o   = w_sel_req & ~w_full;
  assign mem_addr_o  = w_sel_sb ? sb_addr_i  : core_addr_i;
  assign mem_we_o    = w_sel_sb ? sb_we_i    : core_we_i;
  assign mem_be_o    = w_sel_sb ? sb_be_i    : core_be_i;
  assign mem_wdata_o = w_sel_sb ? sb_wdata_i : core_wdata_i;

  assign w_hs        = mem_req_o & mem_gnt_i;
  assign core_gnt_o  = w_hs & ~w_sel_sb;
  assign sb_gnt_o    = w_hs & w_sel_sb;

  assign w_push_route = w_sel_sb ? ROUTE_SB : ROUTE_CORE;
  assign w_head_route = route_e'(w_head);
  assign w_pop        = mem_rvalid_i & ~w_empty;

  assign core_rvalid_o = w_pop & (w_head_route == ROUTE_CORE);
  assign sb_rvalid_o   = w_pop & (w_head_route == ROUTE_SB);
  assign core_rdata_o  = mem_rdata_i;
  assign sb_rdata_o    = mem_rdata_i;
  assign err_o         = r_err;

  tb_route_fifo #(
    .DEPTH (MaxOutstanding),
    .WIDTH (1)
  ) u_route_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_hs),
    .i_data  (w_push_route),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_usage (w_usage)
  );

  // last_sb resets high so the core wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_sb <= 1'b1;
      r_lock    <= 1'b0;
      r_lock_sb <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_hs) r_last_sb <= w_sel_sb;
      if (mem_req_o && !mem_gnt_i) begin
        r_lock    <= 1'b1;
        r_lock_sb <= w_sel_sb;
      end else if (w_hs) begin
        r_lock <= 1'b0;
      end
      if (mem_rvalid_i && w_empty) r_err <= 1'b1;
    end
  end

  // Occupancy and the full flag must agree.
  always_ff @(posedge clk_i) begin
    if (rst_ni) assert (w_full == (w_usage == CntW'(MaxOutstanding)));
  end

endmodule

// File: tb/tb_tb_sba_data_arbiter.sv
// Directed bench for the core/SBA arbiter: stimulus queues expected responses,
// a negedge monitor checks every rvalid against that queue.
module tb_tb_sba_data_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;

  logic        core_req_i = 0, core_we_i = 0, sb_req_i = 0, sb_we_i = 0;
  logic [31:0] core_addr_i = 0, core_wdata_i = 0, sb_addr_i = 0, sb_wdata_i = 0;
  logic [3:0]  core_be_i = 4'hF, sb_be_i = 4'hF;
  logic        mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [31:0] mem_rdata_i = 0;
  logic        core_gnt_o, core_rvalid_o, sb_gnt_o, sb_rvalid_o, mem_req_o, mem_we_o, err_o;
  logic [31:0] core_rdata_o, sb_rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;

  logic        p_core_req = 0, p_sb_req = 0, p_mem_gnt = 0, p_mem_rvalid = 0;
  logic [31:0] p_core_addr = 32'h800, p_sb_addr = 32'h700, p_mem_rdata = 0;
  logic        p_core_gnt, p_core_rvalid, p_sb_gnt, p_sb_rvalid, p_mem_req, p_mem_we, p_err;
  logic [31:0] p_core_rdata, p_sb_rdata, p_mem_addr, p_mem_wdata;
  logic [3:0]  p_mem_be;

  typedef struct {
    logic        sb;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  tb_sba_data_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_addr_i(core_addr_i),
    .core_we_i(core_we_i), .core_be_i(core_be_i), .core_wdata_i(core_wdata_i),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .sb_req_i(sb_req_i), .sb_gnt_o(sb_gnt_o), .sb_addr_i(sb_addr_i),
    .sb_we_i(sb_we_i), .sb_be_i(sb_be_i), .sb_wdata_i(sb_wdata_i),
    .sb_rvalid_o(sb_rvalid_o), .sb_rdata_o(sb_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  tb_sba_data_arbiter #(.SbaPriority(1)) dut_prio (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(p_core_req), .core_gnt_o(p_core_gnt), .core_addr_i(p_core_addr),
    .core_we_i(1'b0), .core_be_i(4'hF), .core_wdata_i(32'h0),
    .core_rvalid_o(p_core_rvalid), .core_rdata_o(p_core_rdata),
    .sb_req_i(p_sb_req), .sb_gnt_o(p_sb_gnt), .sb_addr_i(p_sb_addr),
    .sb_we_i(1'b0), .sb_be_i(4'hF), .sb_wdata_i(32'h0),
    .sb_rvalid_o(p_sb_rvalid), .sb_rdata_o(p_sb_rdata),
    .mem_req_o(p_mem_req), .mem_gnt_i(p_mem_gnt), .mem_addr_o(p_mem_addr),
    .mem_we_o(p_mem_we), .mem_be_o(p_mem_be), .mem_wdata_o(p_mem_wdata),
    .mem_rvalid_i(p_mem_rvalid), .mem_rdata_i(p_mem_rdata), .err_o(p_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic expect_rsp(input logic sb, input logic [31:0] data);
    exp_t e;
    e.sb   = sb;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Response monitor for the round-robin instance.
  always @(negedge clk_i) begin
    if (rst_ni && (core_rvalid_o || sb_rvalid_o)) begin
      exp_t e;
      chk("rvalid_onehot", {31'b0, core_rvalid_o & sb_rvalid_o}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual core=%b sb=%b required=no rvalid",
                 core_rvalid_o, sb_rvalid_o);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_route", {31'b0, sb_rvalid_o}, {31'b0, e.sb});
        chk("rsp_data", sb_rvalid_o ? sb_rdata_o : core_rdata_o, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [3:0] rr_sb;
    rr_sb = 4'b1010;

    #2;
    chk("reset_err", {31'b0, err_o}, 32'd0);
    chk("reset_mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("reset_prio_err", {31'b0, p_err}, 32'd0);
    next_cyc();
    rst_ni = 1'b1;

    // Round-robin alternation, single-cycle RAM; first tie goes to core.
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      core_req_i = 1; core_addr_i = 32'h200; core_we_i = 1; core_wdata_i = 32'hC0C0_0000 + 32'(k);
      sb_req_i = 1; sb_addr_i = 32'h300; sb_we_i = 0;
      mem_gnt_i = 1; mem_rvalid_i = (k > 0);
      mem_rdata_i = 32'h0000_1000 + 32'(k) - 32'd1;
      settle();
      chk("rr_core_gnt", {31'b0, core_gnt_o}, {31'b0, ~rr_sb[k]});
      chk("rr_sb_gnt", {31'b0, sb_gnt_o}, {31'b0, rr_sb[k]});
      chk("rr_addr", mem_addr_o, rr_sb[k] ? 32'h300 : 32'h200);
      if (!rr_sb[k]) chk("rr_wdata", mem_wdata_o, 32'hC0C0_0000 + 32'(k));
      expect_rsp(rr_sb[k], 32'h0000_1000 + 32'(k));
    end
    next_cyc();
    core_req_i = 0; sb_req_i = 0; core_we_i = 0; mem_gnt_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'h0000_1003;
    settle();
    chk("rr_idle_req", {31'b0, mem_req_o}, 32'd0);
    next_cyc();
    mem_rvalid_i = 0;

    // Core-only read, same-cycle grant, response next cycle.
    next_cyc();
    core_req_i = 1; core_addr_i = 32'h100; mem_gnt_i = 1;
    settle();
    chk("rd_core_gnt", {31'b0, core_gnt_o}, 32'd1);
    chk("rd_sb_gnt", {31'b0, sb_gnt_o}, 32'd0);
    chk("rd_addr", mem_addr_o, 32'h100);
    expect_rsp(1'b0, 32'hDEAD_BEEF);
    next_cyc();
    core_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    settle();
    chk("rd_core_rvalid", {31'b0, core_rvalid_o}, 32'd1);
    chk("rd_sb_rvalid", {31'b0, sb_rvalid_o}, 32'd0);
    next_cyc();
    mem_rvalid_i = 0;

    // Lock: core waits 3 cycles; SBA (favoured by round-robin) must not preempt.
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      core_req_i = 1; core_addr_i = 32'h400;
      sb_req_i = (k > 0); sb_addr_i = 32'h500;
      mem_gnt_i = (k == 3);
      settle();
      chk("lock_addr", mem_addr_o, 32'h400);
      chk("lock_core_gnt", {31'b0, core_gnt_o}, (k == 3) ? 32'd1 : 32'd0);
      chk("lock_sb_gnt", {31'b0, sb_gnt_o}, 32'd0);
    end
    expect_rsp(1'b0, 32'h4444);
    next_cyc();
    core_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h4444;
    settle();
    chk("unlock_sb_gnt", {31'b0, sb_gnt_o}, 32'd1);
    chk("unlock_addr", mem_addr_o, 32'h500);
    expect_rsp(1'b1, 32'h5555);
    next_cyc();
    sb_req_i = 0; mem_gnt_i = 0; mem_rdata_i = 32'h5555;
    next_cyc();
    mem_rvalid_i = 0;

    // Full FIFO blocks a third request, even in the popping cycle.
    next_cyc();
    core_req_i = 1; core_addr_i = 32'h600; mem_gnt_i = 1;
    settle();
    chk("full_gnt0", {31'b0, core_gnt_o}, 32'd1);
    expect_rsp(1'b0, 32'hA0);
    next_cyc();
    core_addr_i = 32'h604;
    settle();
    chk("full_gnt1", {31'b0, core_gnt_o}, 32'd1);
    expect_rsp(1'b0, 32'hA1);
    next_cyc();
    core_addr_i = 32'h608;
    settle();
    chk("full_block_req", {31'b0, mem_req_o}, 32'd0);
    chk("full_block_gnt", {31'b0, core_gnt_o}, 32'd0);
    next_cyc();
    mem_rvalid_i = 1; mem_rdata_i = 32'hA0;
    settle();
    chk("full_no_bypass", {31'b0, mem_req_o}, 32'd0);
    next_cyc();
    mem_rvalid_i = 0;
    settle();
    chk("full_reissue_req", {31'b0, mem_req_o}, 32'd1);
    chk("full_reissue_gnt", {31'b0, core_gnt_o}, 32'd1);
    expect_rsp(1'b0, 32'hA2);
    next_cyc();
    core_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hA1;
    next_cyc();
    mem_rdata_i = 32'hA2;
    next_cyc();
    mem_rvalid_i = 0;

    // Fixed SBA priority instance.
    for (int k = 0; k < 5; k++) begin
      next_cyc();
      p_core_req = 1; p_sb_req = (k < 4); p_mem_gnt = 1;
      p_mem_rvalid = (k > 0); p_mem_rdata = 32'h0000_2000 + 32'(k) - 32'd1;
      settle();
      chk("prio_sb_gnt", {31'b0, p_sb_gnt}, (k < 4) ? 32'd1 : 32'd0);
      chk("prio_core_gnt", {31'b0, p_core_gnt}, (k < 4) ? 32'd0 : 32'd1);
      chk("prio_addr", p_mem_addr, (k < 4) ? 32'h700 : 32'h800);
      if (k == 1) begin
        chk("prio_sb_rvalid", {31'b0, p_sb_rvalid}, 32'd1);
        chk("prio_sb_rdata", p_sb_rdata, 32'h2000);
      end
    end
    next_cyc();
    p_core_req = 0; p_mem_gnt = 0; p_mem_rvalid = 1; p_mem_rdata = 32'h2FFF;
    settle();
    chk("prio_core_rvalid", {31'b0, p_core_rvalid}, 32'd1);
    chk("prio_core_rdata", p_core_rdata, 32'h2FFF);
    chk("prio_sb_rvalid_off", {31'b0, p_sb_rvalid}, 32'd0);
    next_cyc();
    p_mem_rvalid = 0;

    // Stray response sets sticky error; reset clears it and routing state.
    next_cyc();
    mem_rvalid_i = 1; mem_rdata_i = 32'hBAD;
    settle();
    chk("stray_core_rvalid", {31'b0, core_rvalid_o}, 32'd0);
    chk("stray_sb_rvalid", {31'b0, sb_rvalid_o}, 32'd0);
    chk("stray_err_now", {31'b0, err_o}, 32'd0);
    next_cyc();
    mem_rvalid_i = 0;
    settle();
    chk("stray_err_set", {31'b0, err_o}, 32'd1);
    next_cyc();
    core_req_i = 1; core_addr_i = 32'h900; mem_gnt_i = 1;
    settle();
    chk("stray_err_sticky", {31'b0, err_o}, 32'd1);
    chk("orphan_gnt", {31'b0, core_gnt_o}, 32'd1);
    next_cyc();
    core_req_i = 0; mem_gnt_i = 0; rst_ni = 0;
    settle();
    chk("rst_err_clear", {31'b0, err_o}, 32'd0);
    next_cyc();
    rst_ni = 1;
    next_cyc();
    core_req_i = 1; sb_req_i = 1; core_addr_i = 32'hA00; sb_addr_i = 32'hB00; mem_gnt_i = 1;
    settle();
    chk("rst_tie_core_gnt", {31'b0, core_gnt_o}, 32'd1);
    chk("rst_tie_sb_gnt", {31'b0, sb_gnt_o}, 32'd0);
    expect_rsp(1'b0, 32'h7777);
    next_cyc();
    core_req_i = 0; sb_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h7777;
    next_cyc();
    mem_rdata_i = 32'hBAD2;
    settle();
    chk("rst_fifo_empty", {31'b0, core_rvalid_o | sb_rvalid_o}, 32'd0);
    next_cyc();
    mem_rvalid_i = 0;
    settle();
    chk("rst_stray_err", {31'b0, err_o}, 32'd1);

    next_cyc();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
